// File: rtl/dcr_exe_pkg.sv
// Shared types and select encodings for the multi-cycle execute stage.
package dcr_exe_pkg;

    typedef enum logic [1:0] {
        MD_NONE  = 2'd0,
        MD_MULLO = 2'd1,
        MD_DIVQ  = 2'd2,
        MD_DIVR  = 2'd3
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [1:0] BYP_REG = 2'd0;
    localparam logic [1:0] BYP_MEM = 2'd1;
    localparam logic [1:0] BYP_WB  = 2'd2;

    localparam logic [1:0] SRCX_RS    = 2'd0;
    localparam logic [1:0] SRCX_PC    = 2'd1;
    localparam logic [1:0] SRCX_SHAMT = 2'd2;
    localparam logic [1:0] SRCX_C16   = 2'd3;

    localparam logic [1:0] SRCY_RT  = 2'd0;
    localparam logic [1:0] SRCY_IMM = 2'd1;
    localparam logic [1:0] SRCY_ONE = 2'd2;
    localparam logic [1:0] SRCY_RT2 = 2'd3;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;

endpackage

// File: rtl/dcr_ALU.sv
// Single-cycle ALU; shifts move Y by the low bits of X.
module dcr_ALU
    import dcr_exe_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]        i_ctrl,
    input  logic [DATA_W-1:0] i_x,
    input  logic [DATA_W-1:0] i_y,
    output logic [DATA_W-1:0] o_result
);

    localparam int SH_W = $clog2(DATA_W);

    logic [SH_W-1:0] w_sh;

    assign w_sh = i_x[SH_W-1:0];

    always_comb begin
        o_result = '0;
        case (i_ctrl)
            ALU_ADD:  o_result = i_x + i_y;
            ALU_SUB:  o_result = i_x - i_y;
            ALU_AND:  o_result = i_x & i_y;
            ALU_OR:   o_result = i_x | i_y;
            ALU_XOR:  o_result = i_x ^ i_y;
            ALU_NOR:  o_result = ~(i_x | i_y);
            ALU_SLT:  o_result = DATA_W'($signed(i_x) < $signed(i_y));
            ALU_SLTU: o_result = DATA_W'(i_x < i_y);
            ALU_SLL:  o_result = i_y << w_sh;
            ALU_SRL:  o_result = i_y >> w_sh;
            ALU_SRA:  o_result = $signed(i_y) >>> w_sh;
            default:  o_result = '0;
        endcase
    end

endmodule

// File: rtl/dcr_iter_muldiv.sv
// One-bit-per-step shift-add multiplier and restoring divider (unsigned).
module dcr_iter_muldiv
    import dcr_exe_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_step,
    input  muldiv_op_e        i_op,
    input  logic [DATA_W-1:0] i_x,
    input  logic [DATA_W-1:0] i_y,
    output logic [DATA_W-1:0] o_result
);

    muldiv_op_e        r_op;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W:0]   r_acc;
    logic [DATA_W:0]   w_rem_sh;
    logic [DATA_W:0]   w_diff;

    // r_a: multiplicand (mul) or dividend shifting into quotient (div)
    assign w_rem_sh = {r_acc[DATA_W-1:0], r_a[DATA_W-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op  <= MD_NONE;
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
        end else if (i_load) begin
            r_op  <= i_op;
            r_a   <= i_x;
            r_b   <= i_y;
            r_acc <= '0;
        end else if (i_step) begin
            if (r_op == MD_MULLO) begin
                if (r_b[0])
                    r_acc <= r_acc + {1'b0, r_a};
                r_a <= r_a << 1;
                r_b <= r_b >> 1;
            end else if (!w_diff[DATA_W]) begin
                r_acc <= w_diff;
                r_a   <= {r_a[DATA_W-2:0], 1'b1};
            end else begin
                r_acc <= w_rem_sh;
                r_a   <= {r_a[DATA_W-2:0], 1'b0};
            end
        end
    end

    assign o_result = (r_op == MD_DIVQ) ? r_a : r_acc[DATA_W-1:0];

endmodule

// File: rtl/dcr_execute_mc.sv
// Execute stage with forwarding and iterative MULLO/DIVQ/DIVR.
// Divide support is built only when DCR_EXE_DIV_EN is defined.
module dcr_execute_mc
    import dcr_exe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clken,
    input  logic              ValidInEXE,
    input  logic              FlushInEXE,
    input  logic [1:0]        BypassRsInEXE,
    input  logic [1:0]        BypassRtInEXE,
    input  logic [DATA_W-1:0] RofRsInEXE,
    input  logic [DATA_W-1:0] RofRtInEXE,
    input  logic [DATA_W-1:0] ShamtInEXE,
    input  logic [DATA_W-1:0] ImmInEXE,
    input  logic [DATA_W-1:0] PCPlusOneInEXE,
    input  logic [DATA_W-1:0] MEMMEMBypassDataInEXE,
    input  logic [DATA_W-1:0] WBBypassDataInEXE,
    input  logic [3:0]        ALUControlInEXE,
    input  logic [1:0]        ALUSrcXInEXE,
    input  logic [1:0]        ALUSrcYInEXE,
    input  logic [1:0]        MulDivOpInEXE,
    output logic [DATA_W-1:0] ALUResultOutMEM,
    output logic              ValidOutMEM,
    output logic [DATA_W-1:0] RofRtOutMEM,
    output logic [ADDR_W-1:0] ALUAddrOutMEM,
    output logic [DATA_W-1:0] EXEBypassDataOutID,
    output logic              StallOutID
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    logic [DATA_W-1:0] w_rs;
    logic [DATA_W-1:0] w_rt;
    logic [DATA_W-1:0] w_x;
    logic [DATA_W-1:0] w_y;
    logic [DATA_W-1:0] w_alu;
    logic [DATA_W-1:0] w_sc_res;
    logic [DATA_W-1:0] w_md_res;
    logic              w_md;
    logic              w_accept;
    logic              w_last;
    muldiv_op_e        w_op;

    state_e            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_result;
    logic              r_valid;

    assign w_op = muldiv_op_e'(MulDivOpInEXE);

    always_comb begin
        w_rs = RofRsInEXE;
        w_rt = RofRtInEXE;
        case (BypassRsInEXE)
            BYP_MEM: w_rs = MEMMEMBypassDataInEXE;
            BYP_WB:  w_rs = WBBypassDataInEXE;
            default: w_rs = RofRsInEXE;
        endcase
        case (BypassRtInEXE)
            BYP_MEM: w_rt = MEMMEMBypassDataInEXE;
            BYP_WB:  w_rt = WBBypassDataInEXE;
            default: w_rt = RofRtInEXE;
        endcase
    end

    always_comb begin
        w_x = w_rs;
        w_y = w_rt;
        case (ALUSrcXInEXE)
            SRCX_PC:    w_x = PCPlusOneInEXE;
            SRCX_SHAMT: w_x = ShamtInEXE;
            SRCX_C16:   w_x = DATA_W'(16);
            default:    w_x = w_rs;
        endcase
        case (ALUSrcYInEXE)
            SRCY_IMM: w_y = ImmInEXE;
            SRCY_ONE: w_y = DATA_W'(1);
            default:  w_y = w_rt;
        endcase
    end

    dcr_ALU #(.DATA_W(DATA_W)) u_alu (
        .i_ctrl   (ALUControlInEXE),
        .i_x      (w_x),
        .i_y      (w_y),
        .o_result (w_alu)
    );

`ifdef DCR_EXE_DIV_EN
    assign w_md     = (w_op != MD_NONE);
    assign w_sc_res = w_alu;
`else
    // Divides retire immediately with a zero result in this build
    assign w_md     = (w_op == MD_MULLO);
    assign w_sc_res = (w_op == MD_NONE) ? w_alu : '0;
`endif

    assign w_accept = (r_state == ST_IDLE) & ValidInEXE & w_md
                    & clken & !FlushInEXE;
    assign w_last   = (r_cnt == CNT_W'(DATA_W - 1));

    dcr_iter_muldiv #(.DATA_W(DATA_W)) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_accept),
        .i_step   (r_state == ST_BUSY),
        .i_op     (w_op),
        .i_x      (w_x),
        .i_y      (w_y),
        .o_result (w_md_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_result <= '0;
            r_valid  <= 1'b0;
        end else if (FlushInEXE) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_BUSY;
                        r_cnt   <= '0;
                        r_valid <= 1'b0;
                    end else if (clken) begin
                        r_valid <= ValidInEXE;
                        if (ValidInEXE)
                            r_result <= w_sc_res;
                    end
                end
                ST_BUSY: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last)
                        r_state <= ST_DONE;
                    if (clken)
                        r_valid <= 1'b0;
                end
                ST_DONE: begin
                    if (clken) begin
                        r_state  <= ST_IDLE;
                        r_result <= w_md_res;
                        r_valid  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        case (r_state)
            ST_BUSY: EXEBypassDataOutID = '0;
            ST_DONE: EXEBypassDataOutID = w_md_res;
            default: EXEBypassDataOutID = w_sc_res;
        endcase
    end

    assign StallOutID      = rst_n & (w_accept | (r_state != ST_IDLE));
    assign ALUResultOutMEM = r_result;
    assign ValidOutMEM     = r_valid;
    assign RofRtOutMEM     = RofRtInEXE;
    assign ALUAddrOutMEM   = w_alu[ADDR_W-1:0];

endmodule

// File: doc/dcr_execute_mc.md
DCR_EXECUTE_MC -- requirements
Module: dcr_execute_mc

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width (8..64).
REQ-002 SHALL have parameter ADDR_W, default 8, width of data-memory address output.
REQ-003 SHALL have ports: clk in 1 clock; rst_n in 1 reset, asynchronous, active-low.
REQ-004 SHALL have ports: clken in 1 pipeline advance; ValidInEXE in 1 instruction valid; FlushInEXE in 1 abort.
REQ-005 SHALL have ports: BypassRsInEXE, BypassRtInEXE in 2 each, forward select (0 reg, 1 MEM, 2 WB).
REQ-006 SHALL have ports: RofRsInEXE, RofRtInEXE, ShamtInEXE, ImmInEXE, PCPlusOneInEXE, MEMMEMBypassDataInEXE, WBBypassDataInEXE in DATA_W each.
REQ-007 SHALL have ports: ALUControlInEXE in 4; ALUSrcXInEXE, ALUSrcYInEXE in 2; MulDivOpInEXE in 2 (0 none, 1 MULLO, 2 DIVQ, 3 DIVR).
REQ-008 SHALL have ports: ALUResultOutMEM out DATA_W; ValidOutMEM out 1; RofRtOutMEM out DATA_W; ALUAddrOutMEM out ADDR_W; EXEBypassDataOutID out DATA_W; StallOutID out 1.

Function
REQ-009 Operand forwarding and X/Y source select SHALL be combinational: X 0 Rs, 1 PC+1, 2 shamt, 3 constant 16; Y 0 Rt, 1 imm, 2 constant 1, 3 Rt.
REQ-010 RofRtOutMEM SHALL pass RofRtInEXE unregistered; ALUAddrOutMEM SHALL be ALU result[ADDR_W-1:0] unregistered.
REQ-011 Single-cycle op (MulDivOp=0, valid): on clk edge with clken, ALUResultOutMEM <= ALU result, ValidOutMEM <= 1; latency 1.
REQ-012 ValidInEXE=0 with clken SHALL load ValidOutMEM <= 0; ALUResultOutMEM holds.
REQ-013 clken=0 SHALL hold ALUResultOutMEM and ValidOutMEM.
REQ-014 FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-015 IDLE->BUSY when ValidInEXE & MulDivOp!=0 & clken & !FlushInEXE; forwarded X/Y operands and op latched, iteration counter cleared.
REQ-016 BUSY SHALL run one unsigned iteration per clk (independent of clken); after exactly DATA_W iterations -> DONE.
REQ-017 DONE->IDLE on first edge with clken: ALUResultOutMEM <= product low / quotient / remainder, ValidOutMEM <= 1.
REQ-018 StallOutID SHALL be 1 combinationally in the accepting cycle and throughout BUSY and DONE; 0 otherwise.
REQ-019 While BUSY or DONE-without-clken, clken edges SHALL load ValidOutMEM <= 0 (bubble) except the completing DONE edge.
REQ-020 Divide by zero: quotient all ones, remainder = dividend.
REQ-021 FlushInEXE=1 SHALL force state IDLE and ValidOutMEM <= 0 on next edge, regardless of clken; flush has priority over acceptance and completion.
REQ-022 EXEBypassDataOutID SHALL be the single-cycle ALU result in IDLE, the mul/div result in DONE, and 0 in BUSY.

Reset
REQ-023 rst_n=0 SHALL asynchronously clear ALUResultOutMEM, ValidOutMEM, counter, operand/accumulator registers, and set state IDLE; StallOutID 0 during reset.
REQ-024 Reset asserted mid-operation SHALL discard the operation; no result is emitted after release.

Configuration
REQ-025 With DCR_EXE_DIV_EN defined, DIVQ/DIVR SHALL be implemented per REQ-015..020.
REQ-026 Without DCR_EXE_DIV_EN, DIVQ/DIVR SHALL complete single-cycle with result 0 and no stall; MULLO unaffected.

Structure
REQ-027 Package dcr_exe_pkg SHALL hold mul/div op enum, FSM state enum, bypass and ALU-source select constants.
REQ-028 Iterative shift-add multiplier / restoring divider SHALL be sub-module dcr_iter_muldiv; existing dcr_ALU instantiated for single-cycle ops.

Verification (DATA_W=32, clken=1 unless stated)
REQ-029 ADD via ALU, Rs=5, Rt=3, bypass Rs=1 with MEM data=10 -> ALUResultOutMEM=13, ValidOutMEM=1 after 1 edge.
REQ-030 MULLO 7x6 -> StallOutID 1 for 34 cycles, bubbles meanwhile, then ALUResultOutMEM=42, ValidOutMEM=1.
REQ-031 DIVQ 100/7 -> 14; DIVR 100/7 -> 2; DIVQ 9/0 -> 0xFFFFFFFF; DIVR 9/0 -> 9.
REQ-032 MULLO accepted, clken held 0 in DONE for 5 cycles -> result held, stall stays 1, emitted on first clken edge.
REQ-033 FlushInEXE at iteration 10 -> IDLE next edge, StallOutID 0, ValidOutMEM 0; rst_n low at iteration 10 -> same, no late result.
REQ-034 Build without DCR_EXE_DIV_EN: DIVQ 100/7 -> result 0, ValidOutMEM 1 after 1 edge, StallOutID never 1.
